// File: rtl/soc_pm_cfg_shifter_if.sv
// Pixel-matrix digital configuration bundle shared between the SoC register block
// (master) and the configuration shifter (slave).
interface soc_pm_digital_config;
   logic [25:0] res;
   logic [2:0]  num_bit_sel;
   logic        lc_mode;
   logic        limit_enable;
   logic        sample_mode;

   modport master (
      output res, num_bit_sel, lc_mode, limit_enable, sample_mode
   );

   modport slave (
      input  res, num_bit_sel, lc_mode, limit_enable, sample_mode
   );
endinterface

// File: rtl/soc_pm_cfg_shifter.sv
// Snapshots the 32-bit pixel-matrix configuration word on start, shifts it MSB first on a
// divided shift clock, then pulses the latch strobe to commit the chain.
module soc_pm_cfg_shifter #(
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned LATCH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   soc_pm_digital_config.slave cfg,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                pm_cfg_sdo,
   output logic                pm_cfg_sclk,
   output logic                pm_cfg_latch
);

   localparam int unsigned DW = $clog2(CLK_DIV + 1);
   localparam int unsigned LW = $clog2(LATCH_CYCLES + 1);

   if (CLK_DIV == 0) begin : g_bad_clk_div
      $error("soc_pm_cfg_shifter: CLK_DIV must be >= 1");
   end
   if (LATCH_CYCLES == 0) begin : g_bad_latch_cycles
      $error("soc_pm_cfg_shifter: LATCH_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {StIdle, StLow, StHigh, StLatch} state_e;

   state_e          r_state, w_state;
   logic [DW-1:0]   r_div_cnt, w_div_cnt;
   logic [LW-1:0]   r_lat_cnt, w_lat_cnt;
   logic [4:0]      r_bit_cnt, w_bit_cnt;
   logic [31:0]     r_shift, w_shift;
   logic            r_busy, w_busy;
   logic            r_done, w_done;
   logic            r_sdo, w_sdo;
   logic            r_sclk, w_sclk;
   logic            r_latch, w_latch;

   logic [31:0]     w_word;
   logic            w_div_end;
   logic            w_lat_end;

   assign w_word    = {cfg.sample_mode, cfg.limit_enable, cfg.lc_mode, cfg.num_bit_sel, cfg.res};
   assign w_div_end = (r_div_cnt == DW'(CLK_DIV - 1));
   assign w_lat_end = (r_lat_cnt == LW'(LATCH_CYCLES - 1));

   always_comb begin
      w_state   = r_state;
      w_div_cnt = r_div_cnt;
      w_lat_cnt = r_lat_cnt;
      w_bit_cnt = r_bit_cnt;
      w_shift   = r_shift;
      w_busy    = r_busy;
      w_done    = 1'b0;
      w_sdo     = r_sdo;
      w_sclk    = r_sclk;
      w_latch   = r_latch;

      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_state   = StLow;
               w_shift   = w_word;
               w_sdo     = w_word[31];
               w_bit_cnt = 5'd31;
               w_div_cnt = '0;
               w_busy    = 1'b1;
            end
         end
         StLow: begin
            if (w_div_end) begin
               w_div_cnt = '0;
               w_sclk    = 1'b1;
               w_state   = StHigh;
            end else begin
               w_div_cnt = r_div_cnt + DW'(1);
            end
         end
         StHigh: begin
            if (w_div_end) begin
               w_div_cnt = '0;
               w_sclk    = 1'b0;
               if (r_bit_cnt != 5'd0) begin
                  // Next bit leaves together with the sclk falling edge.
                  w_bit_cnt = r_bit_cnt - 5'd1;
                  w_shift   = {r_shift[30:0], 1'b0};
                  w_sdo     = r_shift[30];
                  w_state   = StLow;
               end else begin
                  w_lat_cnt = '0;
                  w_latch   = 1'b1;
                  w_state   = StLatch;
               end
            end else begin
               w_div_cnt = r_div_cnt + DW'(1);
            end
         end
         StLatch: begin
            if (w_lat_end) begin
               w_lat_cnt = '0;
               w_latch   = 1'b0;
               w_busy    = 1'b0;
               w_done    = 1'b1;
               w_state   = StIdle;
            end else begin
               w_lat_cnt = r_lat_cnt + LW'(1);
            end
         end
         default: begin
            w_state = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_div_cnt <= '0;
         r_lat_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sdo     <= 1'b0;
         r_sclk    <= 1'b0;
         r_latch   <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_div_cnt <= w_div_cnt;
         r_lat_cnt <= w_lat_cnt;
         r_bit_cnt <= w_bit_cnt;
         r_shift   <= w_shift;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_sdo     <= w_sdo;
         r_sclk    <= w_sclk;
         r_latch   <= w_latch;
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign pm_cfg_sdo   = r_sdo;
   assign pm_cfg_sclk  = r_sclk;
   assign pm_cfg_latch = r_latch;

endmodule

// File: doc/soc_pm_cfg_shifter.md
Name: soc_pm_cfg_shifter

Overview:
Consumer of the pixel-matrix digital configuration bundle (soc_pm_digital_config, slave side). On a start request it snapshots the 32 configuration bits. It then serially shifts them into the pixel matrix configuration chain using a generated shift clock, and pulses a latch strobe to commit the chain. It sits between the SoC configuration registers and the pixel matrix pads.

Parameters:
CLK_DIV, 4, half-period of pm_cfg_sclk in clk cycles; legal range >=1 (elaboration error otherwise)
LATCH_CYCLES, 2, width of the pm_cfg_latch pulse in clk cycles; legal range >=1 (elaboration error otherwise)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg  input  soc_pm_digital_config.slave  res[25:0], num_bit_sel[2:0], lc_mode, limit_enable, sample_mode
start  input  1  request to load the configuration; sampled on rising clk edge
busy  output  1  high while a shift/latch sequence is in progress
done  output  1  one-cycle pulse when a sequence completes
pm_cfg_sdo  output  1  serial data to pixel matrix; registered
pm_cfg_sclk  output  1  shift clock to pixel matrix; registered; pixel samples on its rising edge
pm_cfg_latch  output  1  commit strobe to pixel matrix; registered

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; busy, done, pm_cfg_sdo, pm_cfg_sclk, pm_cfg_latch all 0; all counters 0.
- Word format, fixed: word[31]=sample_mode, [30]=limit_enable, [29]=lc_mode, [28:26]=num_bit_sel, [25:0]=res. Shifted MSB first (word[31] first).
- Snapshot: the word is captured into a 32-bit shift register on the edge where start is accepted. Later changes on cfg have no effect until the next accepted start.
- States:
  - IDLE: busy=0. A start seen at edge k captures the word, loads bit_cnt=31 and pm_cfg_sdo=word[31], then goes to LOW. busy=1 from cycle k+1.
  - LOW: pm_cfg_sclk=0 for CLK_DIV cycles, then goes to HIGH.
  - HIGH: pm_cfg_sclk=1 for CLK_DIV cycles.
    - At the end of HIGH with bit_cnt!=0: decrement bit_cnt, drive pm_cfg_sdo with the next bit (sdo changes together with the sclk falling edge), go to LOW.
    - At the end of HIGH with bit_cnt==0: go to LATCH.
  - LATCH: pm_cfg_sclk=0, pm_cfg_latch=1 for LATCH_CYCLES cycles, then goes to IDLE. On entry to IDLE, done=1 for exactly one cycle and busy=0 in that cycle.
- pm_cfg_sdo: holds the last shifted bit after the sequence ends. It returns to 0 only on reset.
- Latency from the accepting edge, where cycle 1 is the first busy cycle:
  - Shift occupies cycles 1..64*CLK_DIV.
  - Latch occupies the next LATCH_CYCLES cycles.
  - done occurs in cycle 64*CLK_DIV+LATCH_CYCLES+1.
  - With defaults: shift 1..256, latch 257..258, done 259.
- Start handling:
  - start while busy=1 is ignored. It is not queued.
  - start in the done cycle is accepted: a new sequence begins and busy=1 in the next cycle.
  - start held high continuously gives back-to-back sequences with one idle/done cycle between them.
- Reset mid-operation: all outputs drop to 0 immediately (asynchronously). No latch pulse is issued and no done is issued. The pixel chain contents are undefined; software must issue a new start.
- Counters:
  - Divider counter width is $clog2(CLK_DIV+1). It wraps to 0 at each phase change.
  - bit_cnt is 5 bits and never wraps below 0.

Test Plan:
1. Assert rst_n=0 with random cfg and start=1 -> busy, done, sdo, sclk, latch all 0. After release with start=0, outputs stay 0 indefinitely.
2. cfg: sample_mode=1, limit_enable=0, lc_mode=1, num_bit_sel=3'b001, res=26'h1234567; pulse start (defaults) -> the 32 bits sampled on sclk rising edges equal 32'hA5234567 MSB first. Expect exactly 32 sclk rising edges, latch high for 2 cycles after the last sclk falls, done in cycle 259, busy high in cycles 1..258.
3. CLK_DIV=1, LATCH_CYCLES=1 -> sclk toggles every cycle and done occurs in cycle 66. The same word is received correctly.
4. Change cfg to all-ones in cycle 10 of a sequence started with 32'hA5234567 -> the received word is still 32'hA5234567. A following start sends 32'hFFFFFFFF.
5. start pulsed in cycle 50 of a sequence -> ignored; exactly one done. start held high -> the second sequence begins the cycle after done, with a done spacing of 259 cycles.
6. Drive rst_n low in cycle 100 of a sequence -> all outputs 0 asynchronously, with no latch and no done. After release, a new start completes normally with the correct word.
